// File: rtl/dbg_iq_capture.sv
// dbg_iq_capture: captures 2^DEPTH_LOG2 consecutive {Q,I} samples from the
// debug channel switch into on-chip RAM, then drains them as a framed byte
// stream (header A5, channel, depth hi, depth lo; then Q hi, Q lo, I hi, I lo
// per sample) over a valid/ready link.
module dbg_iq_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int SEL_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      In_q,
  input  logic [15:0]      In_i,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] sel_ch,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0]           DEPTH_HDR = 16'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] LAST_PTR  = {DEPTH_LOG2{1'b1}};

  typedef enum logic [1:0] {IDLE, CAPTURE, HDR, DATA} state_t;

  state_t                state, state_n;
  logic [SEL_W-1:0]      ch_reg;
  logic [7:0]            ch_byte;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [1:0]            byte_idx;     // header byte index in HDR, byte-in-sample in DATA
  logic [31:0]           rd_word;      // RAM read port, always tracking mem[rd_ptr]
  logic [31:0]           word_q;       // sample currently being serialised
  logic                  last_smp;     // word_q holds sample DEPTH-1
  logic                  out_free;

  // Strobes from the FSM decode into the datapath.
  logic       accept, abort, wr_en, ld_en, ld_word, ld_last, finish;
  logic [7:0] ld_byte;

  logic [31:0] mem [DEPTH];

  assign ch_byte  = 8'(ch_reg);
  // The output register may take a new byte when empty or when its byte
  // leaves this cycle; m_valid itself stays a pure register.
  assign out_free = !m_valid || m_ready;

  // Sample RAM: one write port for capture, one synchronous read port that
  // continuously prefetches the word at rd_ptr.
  // NOTE: the RAM array has no reset; clearing it would prevent block-RAM
  // mapping, and every word is rewritten before it is ever read out.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= {In_q, In_i};
    rd_word <= mem[rd_ptr];
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode and datapath strobes.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    abort   = 1'b0;
    wr_en   = 1'b0;
    ld_en   = 1'b0;
    ld_byte = 8'h00;
    ld_last = 1'b0;
    ld_word = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        // The done cycle still sits in IDLE but must not accept a new start.
        if (start && !done) begin
          accept  = 1'b1;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        // A channel change invalidates the capture and wins over a final write.
        if (sel_ch != ch_reg) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_PTR) begin
            // Preload the sync byte so m_valid rises right after the last write.
            ld_en   = 1'b1;
            ld_byte = 8'hA5;
            state_n = HDR;
          end
        end
      end
      HDR: begin
        if (out_free) begin
          ld_en = 1'b1;
          case (byte_idx)
            2'd1:    ld_byte = ch_byte;
            2'd2:    ld_byte = DEPTH_HDR[15:8];
            default: ld_byte = DEPTH_HDR[7:0];
          endcase
          if (byte_idx == 2'd3) state_n = DATA;
        end
      end
      DATA: begin
        if (m_valid && m_last) begin
          // Final byte is loaded; wait for it to leave, then close the frame.
          if (m_ready) begin
            finish  = 1'b1;
            state_n = IDLE;
          end
        end else if (out_free) begin
          ld_en = 1'b1;
          case (byte_idx)
            2'd0: begin
              ld_byte = rd_word[31:24];
              ld_word = 1'b1;
            end
            2'd1:    ld_byte = word_q[23:16];
            2'd2:    ld_byte = word_q[15:8];
            default: begin
              ld_byte = word_q[7:0];
              ld_last = last_smp;
            end
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: status flags, pointers, sample holding register, output byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_idx <= 2'd0;
      ch_reg   <= '0;
      word_q   <= '0;
      last_smp <= 1'b0;
    end else begin
      done <= finish;

      if (accept) begin
        ch_reg   <= sel_ch;
        err      <= 1'b0;
        busy     <= 1'b1;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        byte_idx <= 2'd0;
        last_smp <= 1'b0;
      end

      if (abort) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end

      if (finish) busy <= 1'b0;

      // Pointers stop at DEPTH-1; a new start rewinds them.
      if (wr_en && wr_ptr != LAST_PTR) wr_ptr <= wr_ptr + 1'b1;

      // Taking a sample into word_q frees the read port, so the next word
      // is prefetched while the remaining three bytes go out.
      if (ld_word) begin
        word_q   <= rd_word;
        last_smp <= (rd_ptr == LAST_PTR);
        if (rd_ptr != LAST_PTR) rd_ptr <= rd_ptr + 1'b1;
      end

      if (ld_en) begin
        m_data   <= ld_byte;
        m_valid  <= 1'b1;
        m_last   <= ld_last;
        byte_idx <= (state == CAPTURE) ? 2'd1 : byte_idx + 2'd1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dbg_iq_capture.sv
// Self-checking bench for dbg_iq_capture with DEPTH_LOG2=4 (16 samples,
// 68-byte frames). Frames are compared against a byte list built from the
// frame format and the samples the bench offered.
module tb_dbg_iq_capture;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int FRAME_LEN  = 4 + 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_q, in_i;
  logic        in_valid;
  logic [7:0]  sel_ch;
  logic        start;
  logic        busy, done, err;
  logic [7:0]  m_data;
  logic        m_valid, m_ready, m_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  got_q[$];
  logic        got_last_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] stored_q[$];

  typedef struct {
    int         vper;     // in_valid every vper cycles
    int         rdy_pct;  // probability (%) of m_ready per cycle
    logic       vstart;   // in_valid with a junk sample on the start cycle
    logic       restart;  // extra start pulses in CAPTURE, DATA and the done cycle
    logic [7:0] ch;
  } scen_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       last;
  } vec_t;

  scen_t scen[4];
  vec_t  vecs[13];

  dbg_iq_capture #(.DEPTH_LOG2(DEPTH_LOG2), .SEL_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .In_q     (in_q),
    .In_i     (in_i),
    .in_valid (in_valid),
    .sel_ch   (sel_ch),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge; inputs set here apply to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame from the format rules and the samples the DUT should keep.
  task automatic build_expected(input logic [7:0] ch);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(ch);
    exp_q.push_back(8'((DEPTH >> 8) & 255));
    exp_q.push_back(8'(DEPTH & 255));
    foreach (stored_q[s]) begin
      exp_q.push_back(stored_q[s][31:24]);
      exp_q.push_back(stored_q[s][23:16]);
      exp_q.push_back(stored_q[s][15:8]);
      exp_q.push_back(stored_q[s][7:0]);
    end
  endtask

  task automatic run_frame(input int vper, input int rdy_pct, input logic vstart,
                           input logic restart, input logic [7:0] ch);
    int         offered, first_valid_cyc, last_cyc;
    logic       got_end, prev_stall, just_filled, rs_cap, rs_dat;
    logic [7:0] prev_data;
    logic       prev_last;
    got_q.delete();
    got_last_q.delete();
    stored_q.delete();

    // Start cycle, optionally with a sample that must not be stored.
    sel_ch   = ch;
    start    = 1'b1;
    in_valid = vstart;
    in_q     = 16'hDEAD;
    in_i     = 16'hBEEF;
    m_ready  = 1'b0;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clear", err, 0);

    offered = 0; first_valid_cyc = -1; last_cyc = 0;
    got_end = 0; prev_stall = 0; just_filled = 0; rs_cap = 0; rs_dat = 0;
    prev_data = 8'h00; prev_last = 1'b0;

    for (int cyc = 0; cyc < 3000 && !got_end; cyc++) begin
      if (just_filled) begin
        check("hdr_latency", m_valid, 1);
        just_filled = 0;
      end
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end

      m_ready  = ($urandom_range(99) < rdy_pct);
      in_valid = ((cyc % vper) == 0);
      in_q     = 16'h1000 + 16'(offered);
      in_i     = 16'h2000 + 16'(offered);
      if (in_valid) begin
        if (stored_q.size() < DEPTH) begin
          stored_q.push_back({in_q, in_i});
          if (stored_q.size() == DEPTH) begin
            check("pre_hdr_idle", m_valid, 0);
            just_filled = 1;
          end
        end
        offered++;
      end

      start = 1'b0;
      if (rs_dat) sel_ch = ch;
      if (restart && !rs_cap && stored_q.size() == 3) begin
        start  = 1'b1;
        rs_cap = 1;
      end
      if (restart && !rs_dat && got_q.size() == 20) begin
        start  = 1'b1;
        sel_ch = ch + 8'd1;
        rs_dat = 1;
      end

      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
        if (m_last) begin
          got_end  = 1;
          last_cyc = cyc;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    sel_ch   = ch;

    if (!got_end) check("frame_end_timeout", 0, 1);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_valid", m_valid, 0);
    if (restart) start = 1'b1;  // start during the done cycle must be ignored
    tick();
    start = 1'b0;
    check("done_pulse_width", done, 0);
    check("post_done_busy", busy, 0);

    if (rdy_pct >= 100 && got_end) check("back_to_back", last_cyc - first_valid_cyc + 1, FRAME_LEN);

    build_expected(ch);
    check("frame_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
      check($sformatf("last%0d", i), got_last_q[i], (i == exp_q.size() - 1) ? 1 : 0);
    end
  endtask

  initial begin
    scen[0] = '{vper: 1, rdy_pct: 100, vstart: 1'b0, restart: 1'b0, ch: 8'd12};
    scen[1] = '{vper: 3, rdy_pct: 50,  vstart: 1'b0, restart: 1'b0, ch: 8'd12};
    scen[2] = '{vper: 2, rdy_pct: 70,  vstart: 1'b1, restart: 1'b1, ch: 8'h5A};
    scen[3] = '{vper: 1, rdy_pct: 100, vstart: 1'b1, restart: 1'b0, ch: 8'd12};

    // Literal bytes of the channel-12 frame with sample k = {1000+k, 2000+k}.
    vecs[0]  = '{idx: 0,  data: 8'hA5, last: 1'b0};
    vecs[1]  = '{idx: 1,  data: 8'h0C, last: 1'b0};
    vecs[2]  = '{idx: 2,  data: 8'h00, last: 1'b0};
    vecs[3]  = '{idx: 3,  data: 8'h10, last: 1'b0};
    vecs[4]  = '{idx: 4,  data: 8'h10, last: 1'b0};
    vecs[5]  = '{idx: 5,  data: 8'h00, last: 1'b0};
    vecs[6]  = '{idx: 6,  data: 8'h20, last: 1'b0};
    vecs[7]  = '{idx: 7,  data: 8'h00, last: 1'b0};
    vecs[8]  = '{idx: 63, data: 8'h0E, last: 1'b0};
    vecs[9]  = '{idx: 64, data: 8'h10, last: 1'b0};
    vecs[10] = '{idx: 65, data: 8'h0F, last: 1'b0};
    vecs[11] = '{idx: 66, data: 8'h20, last: 1'b0};
    vecs[12] = '{idx: 67, data: 8'h0F, last: 1'b1};

    rst = 1'b1; in_q = '0; in_i = '0; in_valid = 1'b0;
    sel_ch = 8'd0; start = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    rst = 1'b0;
    tick();

    for (int s = 0; s < 4; s++) begin
      run_frame(scen[s].vper, scen[s].rdy_pct, scen[s].vstart, scen[s].restart, scen[s].ch);
      if (scen[s].ch == 8'd12) begin
        for (int v = 0; v < 13; v++) begin
          if (vecs[v].idx < got_q.size()) begin
            check($sformatf("vec_data%0d", vecs[v].idx), got_q[vecs[v].idx], vecs[v].data);
            check($sformatf("vec_last%0d", vecs[v].idx), got_last_q[vecs[v].idx], vecs[v].last);
          end else begin
            check($sformatf("vec_missing%0d", vecs[v].idx), got_q.size(), FRAME_LEN);
          end
        end
      end
      tick();
    end

    // Abort: channel changes after 5 captured samples.
    begin
      logic saw_valid, saw_done;
      sel_ch = 8'd12; start = 1'b1; in_valid = 1'b0; m_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1; in_q = 16'h1000 + 16'(k); in_i = 16'h2000 + 16'(k);
        tick();
      end
      sel_ch = 8'd13;
      tick();
      check("abort_err", err, 1);
      check("abort_busy", busy, 0);
      saw_valid = 0; saw_done = 0;
      for (int k = 0; k < 40; k++) begin
        if (m_valid) saw_valid = 1;
        if (done) saw_done = 1;
        tick();
      end
      check("abort_no_valid", saw_valid, 0);
      check("abort_no_done", saw_done, 0);
      check("abort_err_sticky", err, 1);
      in_valid = 1'b0; sel_ch = 8'd12;
      tick();
    end
    run_frame(1, 100, 1'b0, 1'b0, 8'd12);
    tick();

    // Reset while byte 30 is presented in DATA.
    begin
      int   xfers;
      logic hit;
      xfers = 0; hit = 0;
      sel_ch = 8'd12; start = 1'b1; m_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 500 && !hit; k++) begin
        in_valid = 1'b1; in_q = 16'h3000 + 16'(k); in_i = 16'h4000 + 16'(k);
        if (m_valid && xfers == 29) begin
          rst = 1'b1;
          hit = 1;
        end else if (m_valid && m_ready) begin
          xfers++;
        end
        tick();
      end
      rst = 1'b0; in_valid = 1'b0;
      if (!hit) check("rst_mid_timeout", 0, 1);
      check("rst_mid_valid", m_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_last", m_last, 0);
      tick();
    end
    run_frame(3, 60, 1'b0, 1'b0, 8'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
